// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage datapath ALU with an iterative multiply/divide unit.
// The ALU result is purely combinational. Multiply and divide run one bit per
// cycle in a small FSM and write the HI/LO registers when they finish.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             oflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    OP_ADD, OP_OR, OP_SLT, OP_SUB, OP_LUI, OP_AND, OP_XOR, OP_NOR,
    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  localparam int MSB = WIDTH - 1;

  op_e              op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [SHW-1:0]   shamt;

  assign op      = op_e'(aluop);
  assign sum     = a + b;
  assign diff    = {1'b0, a} - {1'b0, b};
  assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
  assign shamt   = a[SHW-1:0];

  // Combinational ALU result; MDU ops leave the pipeline result at zero.
  always_comb begin
    out   = '0;
    oflow = 1'b0;
    case (op)
      OP_ADD:  begin out = sum;              oflow = ovf_add; end
      OP_SUB:  begin out = diff[WIDTH-1:0];  oflow = ovf_sub; end
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
      OP_XOR:  out = a ^ b;
      OP_NOR:  out = ~(a | b);
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
      OP_SLTU: out = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      OP_LUI:  out = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  out = b << shamt;
      OP_SRL:  out = b >> shamt;
      OP_SRA:  out = $signed(b) >>> shamt;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

  // MDU datapath: acc holds {partial product, multiplier} for mult and
  // {remainder, dividend/quotient} for div; both start as {0, |a|}.
  state_e             state;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd_b;
  logic               is_mult;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               is_mdu_op;
  logic               sign_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_mdu_op = (aluop[3:2] == 2'b11);
  assign sign_op   = (op == OP_MULT) || (op == OP_DIV);
  assign abs_a     = (sign_op && a[MSB]) ? -a : a;
  assign abs_b     = (sign_op && b[MSB]) ? -b : b;

  // One shift-add or restoring shift-subtract step per RUN cycle.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, opnd_b};
    if (is_mult)
      step_next = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      step_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign correction applied on the FIX edge; divide by zero forces all ones.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // MDU control FSM: launch, iterate WIDTH steps, then fix up and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      is_mult  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && is_mdu_op) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            count    <= SHW'(WIDTH - 1);
            acc      <= {{WIDTH{1'b0}}, abs_a};
            opnd_b   <= abs_b;
            is_mult  <= ~aluop[1];
            neg_q    <= sign_op && (a[MSB] ^ b[MSB]);
            neg_r    <= sign_op && a[MSB];
            div_zero <= (b == '0);
          end
        end
        S_RUN: begin
          acc <= step_next;
          if (count == '0)
            state <= S_FIX;
          else
            count <= count - 1'b1;
        end
        S_FIX: begin
          if (is_mult) begin
            {hi, lo} <= prod_fix;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: drives a 32-bit and a 16-bit alu_mdu with directed corner
// cases and random operands, comparing against an arithmetic reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  op32 = '0, op16 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        st32 = 1'b0, st16 = 1'b0;

  logic [31:0] out32, hi32, lo32;
  logic        zero32, oflow32, busy32, done32;
  logic [15:0] out16, hi16, lo16;
  logic        zero16, oflow16, busy16, done16;

  int checks = 0;
  int failures = 0;

  logic [63:0] obs_out, obs_hi, obs_lo;
  logic        obs_zero, obs_oflow, obs_busy, obs_done;
  logic [63:0] exp_hi, exp_lo;

  alu_mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .aluop(op32), .a(a32), .b(b32), .start(st32),
    .out(out32), .zero(zero32), .oflow(oflow32), .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32)
  );

  alu_mdu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .aluop(op16), .a(a16), .b(b16), .start(st16),
    .out(out16), .zero(zero16), .oflow(oflow16), .busy(busy16), .done(done16),
    .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input int w, input logic [63:0] v);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic logic [63:0] sv(input int w, input longint v);
    logic [63:0] t;
    t = v;
    return t & mask(w);
  endfunction

  function automatic logic [63:0] rnd(input int w);
    return 64'($urandom) & mask(w);
  endfunction

  // Reference ALU: true integer arithmetic, overflow = result out of range.
  function automatic logic [63:0] modelAlu(input int w, input logic [3:0] op,
                                           input logic [63:0] a, input logic [63:0] b,
                                           output bit ovf);
    longint sa, sb, r, lim_hi, lim_lo;
    logic [63:0] res;
    int sh;
    sa = sext(w, a);
    sb = sext(w, b);
    lim_hi = (longint'(1) << (w - 1)) - 1;
    lim_lo = -(longint'(1) << (w - 1));
    sh = int'(a % w);
    ovf = 1'b0;
    res = '0;
    case (op)
      4'd0:  begin r = sa + sb; ovf = (r > lim_hi) || (r < lim_lo); res = r; end
      4'd3:  begin r = sa - sb; ovf = (r > lim_hi) || (r < lim_lo); res = r; end
      4'd1:  res = a | b;
      4'd5:  res = a & b;
      4'd6:  res = a ^ b;
      4'd7:  res = ~(a | b);
      4'd2:  res = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  res = (a < b) ? 64'd1 : 64'd0;
      4'd4:  res = (b & ((64'd1 << (w / 2)) - 64'd1)) << (w / 2);
      4'd9:  res = b << sh;
      4'd10: res = b >> sh;
      4'd11: begin r = sb >>> sh; res = r; end
      default: res = '0;
    endcase
    return res & mask(w);
  endfunction

  // Reference MDU: full-precision product, truncating division.
  task automatic modelMdu(input int w, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] mh, output logic [63:0] ml);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = sext(w, a);
    sb = sext(w, b);
    mh = '0;
    ml = '0;
    if (op == 4'd12 || op == 4'd13) begin
      if (op == 4'd12) begin q = sa * sb; p = q; end
      else p = a * b;
      mh = (p >> w) & mask(w);
      ml = p & mask(w);
    end else if (b == '0) begin
      ml = mask(w);
      mh = a;
    end else if (op == 4'd14) begin
      q = sa / sb;
      r = sa % sb;
      ml = sv(w, q);
      mh = sv(w, r);
    end else begin
      ml = (a / b) & mask(w);
      mh = (a % b) & mask(w);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int w, input logic [3:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic st);
    if (w == 32) begin
      op32 = op; a32 = a[31:0]; b32 = b[31:0]; st32 = st;
    end else begin
      op16 = op; a16 = a[15:0]; b16 = b[15:0]; st16 = st;
    end
  endtask

  task automatic sampleOutputs(input int w);
    if (w == 32) begin
      obs_out = 64'(out32); obs_hi = 64'(hi32); obs_lo = 64'(lo32);
      obs_zero = zero32; obs_oflow = oflow32; obs_busy = busy32; obs_done = done32;
    end else begin
      obs_out = 64'(out16); obs_hi = 64'(hi16); obs_lo = 64'(lo16);
      obs_zero = zero16; obs_oflow = oflow16; obs_busy = busy16; obs_done = done16;
    end
  endtask

  task automatic checkAlu(input int w, input string tag, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] e;
    bit eovf;
    applyStimulus(w, op, a, b, 1'b0);
    #1;
    sampleOutputs(w);
    e = modelAlu(w, op, a & mask(w), b & mask(w), eovf);
    checkOutput($sformatf("w%0d %s.out", w, tag), obs_out, e);
    checkOutput($sformatf("w%0d %s.zero", w, tag), obs_zero, e == 64'd0);
    checkOutput($sformatf("w%0d %s.oflow", w, tag), obs_oflow, eovf);
  endtask

  // Launch (unless already launched) and follow one MDU op edge by edge.
  task automatic runMdu(input int w, input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input bit pre,
                        input int inject, input bit chain, input logic [3:0] op2,
                        input logic [63:0] a2, input logic [63:0] b2);
    logic [63:0] mh, ml, e;
    bit eovf;
    modelMdu(w, op, a, b, mh, ml);
    if (!pre) applyStimulus(w, op, a, b, 1'b1);
    @(posedge clk); #1;
    applyStimulus(w, op, a, b, 1'b0);
    sampleOutputs(w);
    checkOutput($sformatf("w%0d %s.busy@E0", w, tag), obs_busy, 1'b1);
    for (int k = 1; k <= w + 1; k++) begin
      @(posedge clk); #1;
      sampleOutputs(w);
      checkOutput($sformatf("w%0d %s.busy@E%0d", w, tag, k), obs_busy, k <= w);
      checkOutput($sformatf("w%0d %s.done@E%0d", w, tag, k), obs_done, k == w + 1);
      if (k <= w) begin
        checkOutput($sformatf("w%0d %s.hi_hold@E%0d", w, tag, k), obs_hi, exp_hi);
        checkOutput($sformatf("w%0d %s.lo_hold@E%0d", w, tag, k), obs_lo, exp_lo);
      end
      if (k == 2) begin
        e = modelAlu(w, 4'd0, a ^ b, b, eovf);
        applyStimulus(w, 4'd0, a ^ b, b, 1'b0);
        #1;
        sampleOutputs(w);
        checkOutput($sformatf("w%0d %s.alu_busy", w, tag), obs_out, e);
      end
      if (k == inject - 1) applyStimulus(w, 4'd12, rnd(w), rnd(w), 1'b1);
      if (k == inject) applyStimulus(w, 4'd0, '0, '0, 1'b0);
    end
    checkOutput($sformatf("w%0d %s.hi", w, tag), obs_hi, mh);
    checkOutput($sformatf("w%0d %s.lo", w, tag), obs_lo, ml);
    exp_hi = mh;
    exp_lo = ml;
    if (chain) begin
      applyStimulus(w, op2, a2, b2, 1'b1);
    end else begin
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        sampleOutputs(w);
        checkOutput($sformatf("w%0d %s.done_low", w, tag), obs_done, 1'b0);
        checkOutput($sformatf("w%0d %s.hi_after", w, tag), obs_hi, exp_hi);
        checkOutput($sformatf("w%0d %s.lo_after", w, tag), obs_lo, exp_lo);
      end
    end
  endtask

  task automatic runSuite(input int w);
    logic [63:0] m, mx, mn, ra, rb;
    logic [3:0] rop;
    m  = mask(w);
    mx = m >> 1;
    mn = 64'd1 << (w - 1);

    rst_n = 1'b0;
    #2;
    sampleOutputs(w);
    checkOutput($sformatf("w%0d rst.busy", w), obs_busy, 1'b0);
    checkOutput($sformatf("w%0d rst.done", w), obs_done, 1'b0);
    checkOutput($sformatf("w%0d rst.hi", w), obs_hi, 64'd0);
    checkOutput($sformatf("w%0d rst.lo", w), obs_lo, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;

    checkAlu(w, "add_max_plus1", 4'd0, mx, 64'd1);
    checkAlu(w, "sub_min_minus1", 4'd3, mn, 64'd1);
    checkAlu(w, "sub_equal", 4'd3, 64'd5, 64'd5);
    checkAlu(w, "slt_neg1_1", 4'd2, m, 64'd1);
    checkAlu(w, "sltu_max_1", 4'd8, m, 64'd1);
    checkAlu(w, "lui", 4'd4, 64'd0, 64'h1234);
    checkAlu(w, "sra_min_4", 4'd11, 64'd4, mn);
    checkAlu(w, "srl_min_4", 4'd10, 64'd4, mn);
    checkAlu(w, "sll_0", 4'd9, 64'd0, rnd(w));
    checkAlu(w, "sll_wrap", 4'd9, 64'(w), rnd(w));
    checkAlu(w, "sra_full", 4'd11, 64'(w - 1), mn);
    checkAlu(w, "nor_zero", 4'd7, m, 64'd0);
    for (int i = 12; i < 16; i++) checkAlu(w, "mdu_out", 4'(i), rnd(w), rnd(w));
    if (w == 32) begin
      checkAlu(w, "lit_add", 4'd0, 64'h7FFFFFFF, 64'd1);
      checkOutput("w32 lit_add.value", obs_out, 64'h80000000);
      checkAlu(w, "lit_sra", 4'd11, 64'd4, 64'h80000000);
      checkOutput("w32 lit_sra.value", obs_out, 64'hF8000000);
    end
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      checkAlu(w, $sformatf("rand%0d", i), rop, rnd(w), rnd(w));
    end

    runMdu(w, "mult_m3x5", 4'd12, sv(w, -3), 64'd5, 0, 5, 0, 4'd0, '0, '0);
    if (w == 32) begin
      checkOutput("w32 lit_mult.hi", obs_hi, 64'hFFFFFFFF);
      checkOutput("w32 lit_mult.lo", obs_lo, 64'hFFFFFFF1);
    end
    runMdu(w, "div_m7d2", 4'd14, sv(w, -7), 64'd2, 0, 0, 0, 4'd0, '0, '0);
    runMdu(w, "divu_7d0", 4'd15, 64'd7, 64'd0, 0, 0, 0, 4'd0, '0, '0);
    runMdu(w, "div_m7d0", 4'd14, sv(w, -7), 64'd0, 0, 0, 0, 4'd0, '0, '0);
    runMdu(w, "div_min_m1", 4'd14, mn, m, 0, 0, 0, 4'd0, '0, '0);
    runMdu(w, "mult_minmin", 4'd12, mn, mn, 0, 0, 0, 4'd0, '0, '0);
    runMdu(w, "multu_maxmax", 4'd13, m, m, 0, 0, 0, 4'd0, '0, '0);

    ra = rnd(w);
    rb = 64'($urandom_range(1, 50));
    runMdu(w, "b2b_multu", 4'd13, rnd(w), rnd(w), 0, 0, 1, 4'd15, ra, rb);
    runMdu(w, "b2b_divu", 4'd15, ra, rb, 1, 0, 0, 4'd0, '0, '0);

    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(12, 15));
      ra = rnd(w);
      rb = ($urandom_range(0, 1) == 1) ? sv(w, longint'($urandom_range(0, 40)) - 20) : rnd(w);
      runMdu(w, $sformatf("mdu_rand%0d", i), rop, ra, rb, 0, 0, 0, 4'd0, '0, '0);
    end

    runMdu(w, "pre_reset", 4'd12, mx, mx, 0, 0, 0, 4'd0, '0, '0);
    applyStimulus(w, 4'd13, rnd(w), rnd(w), 1'b1);
    @(posedge clk); #1;
    applyStimulus(w, 4'd13, '0, '0, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sampleOutputs(w);
    checkOutput($sformatf("w%0d midrst.busy", w), obs_busy, 1'b0);
    checkOutput($sformatf("w%0d midrst.done", w), obs_done, 1'b0);
    checkOutput($sformatf("w%0d midrst.hi", w), obs_hi, 64'd0);
    checkOutput($sformatf("w%0d midrst.lo", w), obs_lo, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < w + 4; k++) begin
      @(posedge clk); #1;
      sampleOutputs(w);
      checkOutput($sformatf("w%0d postrst.done", w), obs_done, 1'b0);
      checkOutput($sformatf("w%0d postrst.busy", w), obs_busy, 1'b0);
      checkOutput($sformatf("w%0d postrst.hi", w), obs_hi, 64'd0);
    end
  endtask

  initial begin
    runSuite(32);
    runSuite(16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the single-cycle datapath ALU. It keeps the existing op encodings 0–4. It adds logic, compare-unsigned and shift ops, plus an iterative multiply/divide unit (MDU) that writes dedicated HI/LO registers under a start/busy/done handshake. It sits in the EX stage: the combinational ALU result feeds the pipeline as before, and the control unit stalls on `busy` for mult/div.

## Interface
- `WIDTH`, 32: datapath width. Must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `aluop` in 4: operation select (encoding below).
- `a` in WIDTH: operand A. `a[SHW-1:0]` is the shift amount for shift ops.
- `b` in WIDTH: operand B. Shift source for shift ops.
- `start` in 1: MDU launch. Sampled only when `aluop` is 12–15 and `busy`=0.
- `out` out WIDTH: combinational ALU result.
- `zero` out 1: `out == 0`.
- `oflow` out 1: signed overflow for add/sub; 0 for all other ops.
- `busy` out 1: MDU operation in progress.
- `done` out 1: one-cycle pulse; HI/LO updated on the same edge.
- `hi` out WIDTH, `lo` out WIDTH: MDU result registers.

## Operation
- Encoding: 0 add, 1 or, 2 slt, 3 sub, 4 lui, 5 and, 6 xor, 7 nor, 8 sltu, 9 sll, 10 srl, 11 sra, 12 mult, 13 multu, 14 div, 15 divu.
- lui: `out = {b[WIDTH/2-1:0], WIDTH/2 zeros}`.
- slt/sltu: `out = {zeros, lt}`. Signed compare is `(a-b)[MSB] XOR ovf_sub`; unsigned compare is the borrow of `a-b`.
- Shifts: `out = b <<`, `>>` or `>>>` by `a[SHW-1:0]`. Shift by 0 passes `b` unchanged.
- Overflow rules:
  - add: `ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB])`.
  - sub: `ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB])`.
- Ops 12–15 drive `out = 0`, so `zero = 1`.
- The ALU path is purely combinational and independent of MDU state. It stays valid while `busy`=1.
- MDU FSM states IDLE → RUN → FIX → IDLE:
  - IDLE: on `start` with op 12–15, latch the op, `|a|`, `|b|` (magnitudes for signed ops, raw values for unsigned) and the result sign. Go to RUN, counter = WIDTH−1.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. Decrement the counter; go to FIX when it reaches 0.
  - FIX: apply sign correction to produce the final values.
    - mult: negate the 2·WIDTH product if signs differ.
    - div: quotient is negative if signs differ; remainder takes the sign of dividend `a`.
    - Write `{hi,lo}`, pulse `done`, return to IDLE.
- Results: mult/multu give `{hi,lo} = a*b` (2·WIDTH bits). div/divu give `lo` = quotient (truncated toward zero) and `hi` = remainder.
- Divide by zero: `lo` = all ones, `hi` = `a`. Latency is unchanged.
- Signed min ÷ −1: `lo = min`, `hi = 0`. No flag is raised.
- `start` is ignored while `busy`=1, and ignored in IDLE when `aluop` < 12.
- `hi`/`lo` hold their value except on the `done` edge.

## Timing
- Reset (async assert, sync-safe deassert): FSM → IDLE, `busy`=0, `done`=0, `hi`=`lo`=0, counter = 0.
- Combinational outputs (`out`, `zero`, `oflow`) have no reset dependence.
- Launch edge E0 (start sampled): `busy`=1 after E0.
- RUN occupies edges E1..E(WIDTH).
- FIX edge E(WIDTH+1): `hi`/`lo` written, `busy`→0, `done`→1.
- `done`→0 at E(WIDTH+2).
- Total latency: WIDTH+1 cycles (33 at WIDTH=32).
- Back-to-back operation: `start` is legal in the cycle where `done`=1, because `busy`=0. The new op launches on that edge; `hi`/`lo` keep the just-written result until the next `done`.
- Reset asserted mid-operation aborts the operation immediately. `hi`/`lo` clear to 0, and no `done` is produced.

## Test plan
- add `0x7FFFFFFF + 0x00000001` → `out=0x80000000`, `oflow=1`. sub `0x80000000 − 1` → `0x7FFFFFFF`, `oflow=1`. sub `5 − 5` → `out=0`, `zero=1`, `oflow=0`.
- slt a=`0xFFFFFFFF`, b=1 → 1. sltu with the same operands → 0. lui b=`0x1234` → `0x12340000`.
- sra b=`0x80000000`, a=4 → `0xF8000000`. srl with the same operands → `0x08000000`. sll by 0 → `b`.
- mult a=−3, b=5 with start at E0:
  - `busy`=1 for edges E1..E32.
  - `done`=1 after E33 with `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`.
  - A second `start` at E5 is ignored.
- div a=−7, b=2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. divu a=7, b=0 → `lo=0xFFFFFFFF`, `hi=7`, same 33-cycle latency.
- Back-to-back multu then divu, with the second start in the `done` cycle. Then assert `rst_n`=0 mid-RUN → `busy`, `done`, `hi`, `lo` all go to 0 asynchronously, and no late `done` appears. Repeat the full suite at WIDTH=16.
